reaction_timer: RTL
===================

// Module: reaction_timer
// PURPOSE
//  Response side of the reaction-time game: the stimulus block counts a
//  random delay, then lights the LED (led_on). This block measures the
//  player's response time from led_on to the button press, in ms ticks.
//  It flags presses made before the LED lights (false start) and responses
//  that are too slow (timeout), and keeps the best valid time.
//  It sits between the game controller (arm), the stimulus block (led_on),
//  the raw push-button pin and the score display.
// PARAMETERS
//  TICK_DIV  50000  clk cycles per 1 ms tick (50 MHz clk)
//  MAX_MS    9999   saturation / timeout limit in ms ticks
//  CNT_W     14     width of ms counters; must be >= clog2(MAX_MS+1)
// PORTS
//  clk          in   1      single system clock, all logic on posedge
//  rst_n        in   1      synchronous, active-low reset
//  arm          in   1      level: 1 = run a trial, 0 = abort / return to idle
//  led_on       in   1      stimulus LED state from the stimulus block (synchronous)
//  button       in   1      raw asynchronous push-button, active high
//  clear_best   in   1      1-cycle pulse: reset best_ms to all ones
//  busy         out  1      1 in WAIT_LED or TIMING
//  result_ms    out  CNT_W  last measured time, held until next trial
//  result_valid out  1      1-cycle pulse when result_ms updates
//  timeout      out  1      level: last trial hit MAX_MS
//  false_start  out  1      level: press came before led_on
//  best_ms      out  CNT_W  smallest valid result since reset/clear
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. All outputs are 0, except
//   best_ms, which is all ones. The synchronizer flops, prescaler and
//   counter are cleared.
//  Button path:
//   - 2-flop synchronizer, then rising-edge detect -> press_evt.
//   - The first posedge that samples button=1 is edge N. press_evt is high
//     in the cycle after edge N+2, so the FSM acts on it at edge N+3.
//   - A held button produces only one press_evt.
//  Prescaler: counts 0..TICK_DIV-1 and is cleared on entry to TIMING.
//   ms_tick fires when it wraps, so the first tick comes TICK_DIV cycles
//   after entry.
//  FSM states (encodings in package):
//   IDLE     : arm=1 -> WAIT_LED. Clear timeout, false_start, result_valid.
//   WAIT_LED : press_evt -> FAULT and set false_start=1.
//              led_on=1 -> TIMING and clear ms_count.
//              If press_evt and led_on occur in the same cycle, this is a
//              false start (press_evt has priority).
//   TIMING   : press_evt -> DONE, result_ms=ms_count, result_valid=1.
//              ms_tick with ms_count==MAX_MS-1 -> DONE, result_ms=MAX_MS,
//              timeout=1. If press_evt and that final tick coincide, the
//              press wins and timeout stays 0.
//   DONE     : outputs held; arm=0 -> IDLE.
//   FAULT    : false_start held, result_ms unchanged; arm=0 -> IDLE.
//  arm=0 in WAIT_LED or TIMING -> IDLE at the next edge (abort):
//   - no result_valid, result_ms unchanged, flags stay 0.
//  arm=0 has priority over press_evt and led_on in every state.
//  result_valid is high for exactly the 1 cycle after the DONE entry edge.
//   It is never asserted on timeout or fault.
//  best_ms updates in the same cycle as result_valid if result_ms < best_ms.
//   A timeout never updates best_ms.
//  clear_best sets best_ms to all ones. If it coincides with an update,
//   clear_best wins.
//  ms_count never wraps; it stops at MAX_MS.
//  led_on falling during TIMING is ignored.
// STRUCTURE
//  Package reaction_pkg:
//   - FSM state typedef (IDLE, WAIT_LED, TIMING, DONE, FAULT)
//   - default TICK_DIV and MAX_MS constants
//  Sub-module btn_sync_edge: 2-flop synchronizer plus rising-edge pulse.
//   It has clk/rst_n and will be reused for other player inputs.
//  Top level holds the prescaler, ms counter, FSM and result/best registers.
//  Elaboration check: CNT_W >= clog2(MAX_MS+1).
// TESTING (bench uses TICK_DIV=4, MAX_MS=20)
//  1 Normal trial:
//    arm=1, then led_on=1, then button rises 4*7 cycles later ->
//    result_valid pulses once, result_ms=7 (+/-1 for sync latency),
//    best_ms=7, busy drops.
//  2 False start:
//    button rises in WAIT_LED before led_on ->
//    false_start=1, no result_valid, result_ms and best_ms unchanged.
//    Repeat with press_evt and led_on in the same cycle -> same result.
//  3 Timeout:
//    led_on=1 and no press -> after 20 ticks timeout=1, result_ms=20,
//    no result_valid, best_ms unchanged.
//  4 Best tracking:
//    trials with results 9, 5, 12 -> best_ms=5.
//    Then clear_best -> best_ms=16'h3FFF (all ones).
//  5 Abort and reset:
//    arm=0 mid-TIMING -> IDLE next edge, no result_valid, no flags set.
//    rst_n=0 mid-TIMING -> all outputs at reset values after one edge.
//  6 Held button:
//    button held high through DONE -> IDLE -> new trial ->
//    no spurious press_evt; an actual release and re-press is required.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and default timing constants for the reaction-time game blocks.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LED = 3'd1,
        ST_TIMING   = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV = 50000;  // 50 MHz clk -> 1 ms tick
    localparam int DEF_MAX_MS   = 9999;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw player input followed by a registered
// rising-edge pulse; a held input yields a single pulse.
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1, r_s2, r_s3, r_rise;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/reaction_timer.sv
// Measures LED-to-press response time in ms ticks, flags false starts and
// timeouts, and tracks the best valid time.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int MAX_MS   = DEF_MAX_MS,
    parameter int CNT_W    = 14
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_arm,
    input  logic             i_led_on,
    input  logic             i_button,
    input  logic             i_clear_best,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_result_ms,
    output logic             o_result_valid,
    output logic             o_timeout,
    output logic             o_false_start,
    output logic [CNT_W-1:0] o_best_ms
);

    localparam int               PRE_W  = $clog2(TICK_DIV + 1);
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MS_LAST = CNT_W'(MAX_MS - 1);
    localparam logic [CNT_W-1:0] MS_LIM  = CNT_W'(MAX_MS);

    generate
        if (CNT_W < $clog2(MAX_MS + 1)) begin : g_bad_cnt_w
            $error("reaction_timer: CNT_W too narrow for MAX_MS");
        end
    endgenerate

    state_t             r_state, w_state_nxt;
    logic [PRE_W-1:0]   r_pre;
    logic [CNT_W-1:0]   r_ms, r_result, r_best;
    logic               r_rv, r_tmo, r_fs;
    logic               w_press, w_ms_tick;
    logic               w_arm_start, w_enter_timing, w_hit, w_tmo, w_fs;

    btn_sync_edge u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_button),
        .o_rise  (w_press)
    );

    assign w_ms_tick = (r_pre == PRE_TOP);

    // arm=0 is checked first everywhere; press beats led_on and the final tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_arm_start    = 1'b0;
        w_enter_timing = 1'b0;
        w_hit          = 1'b0;
        w_tmo          = 1'b0;
        w_fs           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_arm) begin
                    w_state_nxt = ST_WAIT_LED;
                    w_arm_start = 1'b1;
                end
            end
            ST_WAIT_LED: begin
                if (!i_arm) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_press) begin
                    w_state_nxt = ST_FAULT;
                    w_fs        = 1'b1;
                end else if (i_led_on) begin
                    w_state_nxt    = ST_TIMING;
                    w_enter_timing = 1'b1;
                end
            end
            ST_TIMING: begin
                if (!i_arm) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_press) begin
                    w_state_nxt = ST_DONE;
                    w_hit       = 1'b1;
                end else if (w_ms_tick && r_ms == MS_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_tmo       = 1'b1;
                end
            end
            ST_DONE, ST_FAULT: begin
                if (!i_arm) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Prescaler idles at 0 outside TIMING, so the first tick lands TICK_DIV after entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || r_state != ST_TIMING) r_pre <= '0;
        else if (w_ms_tick)                   r_pre <= '0;
        else                                  r_pre <= r_pre + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_ms <= '0;
        else if (w_enter_timing)
            r_ms <= '0;
        else if (r_state == ST_TIMING && w_ms_tick && r_ms != MS_LIM)
            r_ms <= r_ms + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_result <= '0;
            r_rv     <= 1'b0;
            r_tmo    <= 1'b0;
            r_fs     <= 1'b0;
        end else begin
            r_rv <= w_hit;
            if (w_arm_start) begin
                r_tmo <= 1'b0;
                r_fs  <= 1'b0;
            end
            if (w_fs)  r_fs <= 1'b1;
            if (w_hit) r_result <= r_ms;
            if (w_tmo) begin
                r_result <= MS_LIM;
                r_tmo    <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear_best) r_best <= '1;
        else if (w_hit && r_ms < r_best) r_best <= r_ms;
    end

    assign o_busy         = (r_state == ST_WAIT_LED) || (r_state == ST_TIMING);
    assign o_result_ms    = r_result;
    assign o_result_valid = r_rv;
    assign o_timeout      = r_tmo;
    assign o_false_start  = r_fs;
    assign o_best_ms      = r_best;

endmodule
